// File: rtl/lcd_pkg.sv
// Shared types, default timing and command constants for the LCD bus driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    DONE
  } lcd_state_t;

  // Default bus timing, in system clock cycles.
  localparam int DEF_T_AS        = 2;
  localparam int DEF_T_PW        = 16;
  localparam int DEF_T_H         = 2;
  localparam int DEF_T_EXEC      = 2000;
  localparam int DEF_T_EXEC_LONG = 82000;
  localparam int DEF_CNT_W       = 18;

  // HD44780 command bytes of interest.
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  // Clear and return-home commands need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing every bus phase; holds at zero once expired.
module lcd_phase_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load wins over counting; the count stops at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780-style write-only bus driver: one byte per start edge, with setup,
// enable-pulse, hold and controller execution timing handled here.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int T_AS        = DEF_T_AS,
  parameter int T_PW        = DEF_T_PW,
  parameter int T_H         = DEF_T_H,
  parameter int T_EXEC      = DEF_T_EXEC,
  parameter int T_EXEC_LONG = DEF_T_EXEC_LONG,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  lcd_state_t       state, next_state;
  logic             start_q;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic [CNT_W-1:0] exec_val;

  // Wait length chosen from the byte already latched onto the bus.
  assign exec_val = is_long_cmd(LCD_RS, LCD_DATA) ? CNT_W'(T_EXEC_LONG - 1)
                                                  : CNT_W'(T_EXEC - 1);

  lcd_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (iCLK),
    .rst_n(iRST_N),
    .load (tmr_load),
    .value(tmr_val),
    .zero (tmr_zero)
  );

  // State register plus previous iStart sample for edge detection.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= next_state;
      start_q <= iStart;
    end
  end

  // Phase sequencing; each phase ends when the shared timer hits zero.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE: begin
        if (iStart && !start_q) begin
          accept     = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(T_AS - 1);
          next_state = SETUP;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(T_PW - 1);
          next_state = PULSE;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(T_H - 1);
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          tmr_load   = 1'b1;
          tmr_val    = exec_val;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (tmr_zero) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus data and register select change only when a transfer is accepted.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
    end else if (accept) begin
      LCD_DATA <= iDATA;
      LCD_RS   <= iRS;
    end
  end

  // Strobes decoded straight from the registered state, so reset clears them at once.
  assign LCD_EN = (state == PULSE);
  assign oBusy  = (state != IDLE);
  assign oDone  = (state == DONE);
  assign LCD_RW = 1'b0;

endmodule
